// File: rtl/mem_access_unit.sv
// Memory access responder for the control unit: one instruction fetch, load or
// store per command over a req/ack word memory, with a done/err completion pulse.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic        fetch_en,
  input  logic [2:0]  bytesel,
  input  logic        mem_write,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] tmo_cnt;

  // Command fields kept for the response phase
  logic       lat_fetch;
  logic       lat_store;
  logic [2:0] lat_size;
  logic [1:0] lat_off;

  logic [31:0] cmd_word;
  logic        cmd_store;
  logic        cmd_bad;
  logic [3:0]  cmd_strb;
  logic [31:0] cmd_wdata;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    cmd_word  = if_en ? {pc[31:2], 2'b00} : {addr[31:2], 2'b00};
    cmd_store = !if_en && mem_write;
    cmd_bad   = 1'b0;
    cmd_strb  = 4'b0000;
    cmd_wdata = wdata;
    if (if_en) begin
      cmd_bad = (pc[1:0] != 2'b00);
    end else begin
      case (bytesel)
        3'b000: begin
          cmd_strb  = 4'b0001 << addr[1:0];
          cmd_wdata = {4{wdata[7:0]}};
        end
        3'b001: begin
          cmd_bad   = addr[0];
          cmd_strb  = 4'b0011 << {addr[1], 1'b0};
          cmd_wdata = {2{wdata[15:0]}};
        end
        3'b010: begin
          cmd_bad  = (addr[1:0] != 2'b00);
          cmd_strb = 4'b1111;
        end
        3'b100:  cmd_bad = mem_write;
        3'b101:  cmd_bad = mem_write || addr[0];
        default: cmd_bad = 1'b1;
      endcase
    end
    if (!cmd_store) cmd_strb = 4'b0000;
  end

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data;

  always_comb begin
    lane_b = mem_rdata[{lat_off, 3'b000} +: 8];
    lane_h = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_size)
      3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext_data = {24'd0, lane_b};
      3'b101:  ext_data = {16'd0, lane_h};
      default: ext_data = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      instr     <= '0;
      load_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      lat_fetch <= 1'b0;
      lat_store <= 1'b0;
      lat_size  <= 3'b000;
      lat_off   <= 2'b00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_en) begin
            lat_fetch <= if_en;
            lat_store <= cmd_store;
            lat_size  <= bytesel;
            lat_off   <= addr[1:0];
            busy      <= 1'b1;
            if (cmd_bad) begin
              // Fault reports during the single FAULT cycle itself
              state <= S_FAULT;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= cmd_store;
              mem_addr  <= cmd_word;
              mem_wdata <= cmd_wdata;
              mem_wstrb <= cmd_strb;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            if (lat_fetch)       instr     <= mem_rdata;
            else if (!lat_store) load_data <= ext_data;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_FAULT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected memory requests
// and completions; independent monitors compare them when the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_en, fetch_en, mem_write, mem_ack;
  logic [2:0]  bytesel;
  logic [31:0] pc, addr, wdata, mem_rdata;
  logic [31:0] instr, load_data, mem_addr, mem_wdata;
  logic        done, err, busy, mem_req, mem_we;
  logic [3:0]  mem_wstrb;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .if_en(if_en), .fetch_en(fetch_en), .bytesel(bytesel),
    .mem_write(mem_write), .pc(pc), .addr(addr), .wdata(wdata),
    .instr(instr), .load_data(load_data), .done(done), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] instr;
    logic [31:0] load_data;
    int          due;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_load  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Completion monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("done_cycle", cyc, r.due);
        check("err", 32'(err), 32'(r.err));
        check("instr", instr, r.instr);
        check("load_data", load_data, r.load_data);
      end
    end
  end

  // Memory request monitor: new request checked on rise, then held stable
  logic req_prev = 1'b0;
  req_t cur_req;
  always @(negedge clk) begin
    if (mem_req === 1'b1 && req_prev !== 1'b1) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", 32'(mem_req), 32'd0);
      end else begin
        cur_req = req_q.pop_front();
        check("mem_addr", mem_addr, cur_req.addr);
        check("mem_we", 32'(mem_we), 32'(cur_req.we));
        if (cur_req.we) begin
          check("mem_wstrb", 32'(mem_wstrb), 32'(cur_req.strb));
          check("mem_wdata", mem_wdata, cur_req.wdata);
        end
      end
    end else if (mem_req === 1'b1) begin
      check("mem_addr_stable", mem_addr, cur_req.addr);
      check("mem_we_stable", 32'(mem_we), 32'(cur_req.we));
      if (cur_req.we) begin
        check("mem_wstrb_stable", 32'(mem_wstrb), 32'(cur_req.strb));
        check("mem_wdata_stable", mem_wdata, cur_req.wdata);
      end
    end
    req_prev = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // f=1: fetch from a; f=0: data access at a. eload is the expected load result.
  task automatic run_cmd(input logic f, input logic [2:0] bs, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input logic illegal,
                         input logic [3:0] estrb, input logic [31:0] ewdata,
                         input logic [31:0] eload, input bit poke);
    int strobe;
    logic st;
    @(negedge clk);
    if_en = f; bytesel = bs; mem_write = w; wdata = wd;
    pc   = f ? a : 32'hFFFF_FFFF;
    addr = f ? 32'hFFFF_FFFF : a;
    fetch_en = 1'b1;
    strobe = cyc;
    st = !f && w;
    if (illegal) begin
      rsp_q.push_back('{1'b1, m_instr, m_load, strobe + 1});
      @(negedge clk);
      fetch_en = 1'b0;
      check("fault_busy", 32'(busy), 32'd1);
      check("fault_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("fault_busy_clear", 32'(busy), 32'd0);
    end else begin
      req_q.push_back('{{a[31:2], 2'b00}, st, estrb, ewdata});
      if (f) m_instr = rd;
      else if (!st) m_load = eload;
      rsp_q.push_back('{1'b0, m_instr, m_load, strobe + 2 + waits});
      @(negedge clk);
      fetch_en = 1'b0;
      for (int i = 0; i < waits; i++) begin
        if (poke && i == 0) begin
          fetch_en = 1'b1; if_en = !f; addr = 32'h0000_1234; pc = 32'h0000_5678;
        end
        @(negedge clk);
        fetch_en = 1'b0;
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'd0;
      check("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b0; if_en = 1'b0; fetch_en = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    bytesel = 3'b000; pc = 32'd0; addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_strb", 32'(mem_wstrb), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_load", load_data, 32'd0);
    rst = 1'b1;

    //       f  bs      w     a             wd            rd            wt ill strb     ewdata        eload         poke
    run_cmd(1, 3'b000, 1'b0, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 0, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b000, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 0);
    run_cmd(0, 3'b100, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 0, 4'b0000, 32'h0,        32'h0000_0080, 1);
    run_cmd(0, 3'b001, 1'b1, 32'h0000_0302, 32'hDEAD_BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0);
    run_cmd(0, 3'b010, 1'b0, 32'h0000_0401, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b001, 1'b0, 32'h0000_0206, 32'h0,        32'h8001_7FFF, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 0);
    run_cmd(0, 3'b101, 1'b0, 32'h0000_0206, 32'h0,        32'h8001_7FFF, 0, 0, 4'b0000, 32'h0,        32'h0000_8001, 0);
    run_cmd(0, 3'b010, 1'b0, 32'h0000_0208, 32'h0,        32'hCAFE_F00D, 2, 0, 4'b0000, 32'h0,        32'hCAFE_F00D, 0);
    run_cmd(0, 3'b000, 1'b1, 32'h0000_0501, 32'h1234_5678, 32'h0,        0, 0, 4'b0010, 32'h7878_7878, 32'h0,        0);
    run_cmd(0, 3'b010, 1'b1, 32'h0000_0600, 32'hA5A5_0F0F, 32'h0,        1, 0, 4'b1111, 32'hA5A5_0F0F, 32'h0,        0);
    run_cmd(1, 3'b000, 1'b0, 32'h0000_0102, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(1, 3'b011, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0013, 1, 0, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b100, 1'b1, 32'h0000_0700, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b011, 1'b0, 32'h0000_0700, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b110, 1'b0, 32'h0000_0700, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);
    run_cmd(0, 3'b001, 1'b0, 32'h0000_0205, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        0);

    // Timeout: no ack, request held 16 cycles then done+err; late ack ignored
    @(negedge clk);
    if_en = 1'b1; pc = 32'h0000_0800; fetch_en = 1'b1;
    req_q.push_back('{32'h0000_0800, 1'b0, 4'b0000, 32'h0});
    rsp_q.push_back('{1'b1, m_instr, m_load, cyc + 17});
    @(negedge clk);
    fetch_en = 1'b0;
    cnt = 0;
    for (int g = 0; g < 40 && mem_req === 1'b1; g++) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", cnt, 32'd16);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'd0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("late_ack_instr", instr, m_instr);

    // Reset mid-access: everything clears, no done, new command accepted after
    @(negedge clk);
    if_en = 1'b1; pc = 32'h0000_0900; fetch_en = 1'b1;
    req_q.push_back('{32'h0000_0900, 1'b0, 4'b0000, 32'h0});
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_load", load_data, 32'd0);
    rst = 1'b1;
    m_instr = 32'd0; m_load = 32'd0;
    run_cmd(1, 3'b000, 1'b0, 32'h0000_000C, 32'h0, 32'h1111_1111, 0, 0, 4'b0000, 32'h0, 32'h0, 0);

    repeat (3) @(negedge clk);
    check("rsp_q_drained", rsp_q.size(), 32'd0);
    check("req_q_drained", req_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
